dac_i2s_serializer: RTL

DAC_I2S_SERIALIZER -- requirements
Module: dac_i2s_serializer

---
 rtl/dac_i2s_serializer.sv | 79 +++++++
 1 files changed

// File: rtl/dac_i2s_serializer.sv
// dac_i2s_serializer: stereo 16-bit I2S transmitter with a one-pair hold register.
// Optional macro DAC_UNDERRUN_COUNT_EN adds a saturating underrun_count output.
module dac_i2s_serializer #(
  parameter int BCLK_DIV = 4
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [15:0] sample_l,
  input  logic [15:0] sample_r,
  input  logic        sample_valid,
  output logic        sample_ready,
  output logic        i2s_bclk,
  output logic        i2s_lrclk,
  output logic        i2s_sdata
`ifdef DAC_UNDERRUN_COUNT_EN
  ,
  output logic [7:0]  underrun_count
`endif
);
  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] RUN  = 1'b1;
  logic [0:0]  state;
  logic [7:0]  div;
  logic [4:0]  slot;
  logic [4:0]  slot_nx;
  logic [31:0] shifter;
  logic [31:0] hold;
  logic        hold_full;
  logic        accept;
  logic        tc;
  logic        fall;
  logic        load;
  assign sample_ready = !hold_full;
  assign accept       = sample_valid && sample_ready;
  assign tc           = div == 8'(BCLK_DIV - 1);
  assign fall         = state == RUN && tc && i2s_bclk;
  assign slot_nx      = slot + 5'd1;
  assign load         = fall && slot_nx == 5'd0;
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      div       <= '0;
      slot      <= '0;
      shifter   <= '0;
      hold      <= '0;
      hold_full <= 1'b0;
      i2s_bclk  <= 1'b0;
      i2s_lrclk <= 1'b1;
      i2s_sdata <= 1'b0;
    end else if (state == IDLE) begin
      if (accept) begin
        state     <= RUN;
        shifter   <= {sample_l, sample_r};
        i2s_lrclk <= 1'b0;
      end
    end else begin
      div <= tc ? 8'd0 : div + 8'd1;
      if (tc) i2s_bclk <= ~i2s_bclk;
      // slot k>0 carries bit 32-k == ~(k-1); slot 0 carries the previous frame's LSB
      if (fall) begin
        slot      <= slot_nx;
        i2s_lrclk <= slot_nx[4];
        i2s_sdata <= load ? shifter[0] : shifter[~slot];
      end
      if (load) shifter <= hold_full ? hold : accept ? {sample_l, sample_r} : 32'h0;
      if (load) hold_full <= 1'b0;
      else if (accept) begin
        hold      <= {sample_l, sample_r};
        hold_full <= 1'b1;
      end
    end
  end
`ifdef DAC_UNDERRUN_COUNT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) underrun_count <= '0;
    else if (load && !hold_full && !accept && underrun_count != 8'hff) underrun_count <= underrun_count + 8'd1;
  end
`endif
endmodule
